free_reg_list: RTL and testbench

// - Free physical-register list feeding the rename stage; supplies NUM_OUT candidate tags per cycle.
// - Slots: [0..W-1] dst, [W..2W-1] immediate temps, [2W..2W+1] NZCV.
// - Reclaims tags that retire frees at ROB commit. A circular FIFO of tags plus an in-list bitmap.

---
 rtl/free_reg_list_pkg.sv | 12 +
 rtl/frl_enq_compact.sv | 47 ++++
 rtl/free_reg_list.sv | 153 +++++++++++++++
 tb/tb_free_reg_list.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/free_reg_list_pkg.sv
// Shared register-file constants and the physical tag type used by rename, ROB and the free list.
package free_reg_list_pkg;

  localparam int DEF_NUM_PHYS_REGS = 64;
  localparam int DEF_NUM_ARCH_REGS = 32;
  localparam int INSTR_Q_WIDTH     = 2;
  localparam int PHYS_TAG_W        = $clog2(DEF_NUM_PHYS_REGS);
  localparam int FRL_SLOTS         = 2*INSTR_Q_WIDTH+2;

  typedef logic [PHYS_TAG_W-1:0] phys_reg_t;

endpackage

// File: rtl/frl_enq_compact.sv
// Packs the unconsumed window slots followed by the accepted frees into a dense enqueue list.
module frl_enq_compact
  import free_reg_list_pkg::*;
#(
  parameter int PW      = PHYS_TAG_W,
  parameter int NUM_OUT = FRL_SLOTS,
  parameter int W       = INSTR_Q_WIDTH,
  localparam int EN     = NUM_OUT + W,
  localparam int EW     = $clog2(NUM_OUT + W + 1)
) (
  input  logic [NUM_OUT*PW-1:0] slot_tags_i,
  input  logic [NUM_OUT-1:0]    keep_i,
  input  logic [W*PW-1:0]       free_tags_i,
  input  logic [W-1:0]          free_ok_i,
  output logic [EN*PW-1:0]      dense_o,
  output logic [EW-1:0]         count_o
);

  logic [PW-1:0] srcTag [EN];
  logic [EN-1:0] srcEn;

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      srcTag[k] = slot_tags_i[k*PW +: PW];
      srcEn[k]  = keep_i[k];
    end
    for (int p = 0; p < W; p++) begin
      srcTag[NUM_OUT+p] = free_tags_i[p*PW +: PW];
      srcEn[NUM_OUT+p]  = free_ok_i[p];
    end
  end

  // Each enabled source lands at the position given by the number of enabled sources before it.
  always_comb begin
    logic [EW-1:0] pos;
    pos     = '0;
    dense_o = '0;
    for (int s = 0; s < EN; s++) begin
      for (int j = 0; j < EN; j++) begin
        if (srcEn[s] && pos == EW'(j)) dense_o[j*PW +: PW] = srcTag[s];
      end
      pos = pos + EW'(srcEn[s]);
    end
    count_o = pos;
  end

endmodule

// File: rtl/free_reg_list.sv
// Free physical-register list: circular tag FIFO plus in-list bitmap, offering NUM_OUT tags per cycle.
module free_reg_list
  import free_reg_list_pkg::*;
#(
  parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
  parameter int W             = INSTR_Q_WIDTH,
  parameter int NUM_OUT       = 2*W+2,
  parameter bit ASSERT_EN     = 1'b1,
  localparam int PW           = $clog2(NUM_PHYS_REGS),
  localparam int CW           = $clog2(NUM_PHYS_REGS+1)
) (
  input  logic                  clk,
  input  logic                  rst_in,
  output logic [NUM_OUT*PW-1:0] free_register_data,
  output logic                  frl_valid,
  input  logic [NUM_OUT-1:0]    frl_ready,
  input  logic [W-1:0]          free_valid,
  input  logic [W*PW-1:0]       free_phys,
  output logic [CW-1:0]         free_count
);

  localparam int EN       = NUM_OUT + W;
  localparam int EW       = $clog2(NUM_OUT + W + 1);
  localparam int INIT_CNT = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;

  logic [PW-1:0]            fifo_q [NUM_PHYS_REGS];
  logic [PW-1:0]            fifo_d [NUM_PHYS_REGS];
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [NUM_PHYS_REGS-1:0] inList_q, inList_d;

  logic [PW-1:0]      slotTag [NUM_OUT];
  logic               pop;
  logic [NUM_OUT-1:0] keepMask;
  logic [CW-1:0]      popReady, freeTaken;
  logic [W-1:0]       freeOk, freeDup, freeDrop;
  logic [EN*PW-1:0]   denseTags;
  logic [EW-1:0]      enqCount;

  // Pointer wrap is done by compare-and-subtract so any register count works.
  function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] base, input int off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(NUM_PHYS_REGS)) s = s - (PW+1)'(NUM_PHYS_REGS);
    return s[PW-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      slotTag[k] = fifo_q[wrapAdd(head_q, k)];
      free_register_data[k*PW +: PW] = slotTag[k];
    end
  end

  assign free_count = count_q;
  assign frl_valid  = (count_q >= CW'(NUM_OUT));
  assign pop        = frl_valid && (|frl_ready);
  assign keepMask   = pop ? ~frl_ready : '0;

  // Frees already in the list (or repeated across ports) are dropped, as are any beyond capacity.
  always_comb begin
    logic [CW:0] room;
    logic [CW:0] taken;
    popReady = '0;
    freeOk   = '0;
    freeDup  = '0;
    freeDrop = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (pop && frl_ready[k]) popReady = popReady + CW'(1);
    end
    room  = (CW+1)'(NUM_PHYS_REGS) - {1'b0, count_q} + {1'b0, popReady};
    taken = '0;
    for (int p = 0; p < W; p++) begin
      if (free_valid[p]) begin
        if (inList_q[free_phys[p*PW +: PW]]) freeDup[p] = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (free_valid[q] && free_phys[q*PW +: PW] == free_phys[p*PW +: PW]) freeDup[p] = 1'b1;
        end
        if (!freeDup[p]) begin
          if (taken < room) begin
            freeOk[p] = 1'b1;
            taken     = taken + (CW+1)'(1);
          end else begin
            freeDrop[p] = 1'b1;
          end
        end
      end
    end
    freeTaken = taken[CW-1:0];
  end

  frl_enq_compact #(
    .PW      (PW),
    .NUM_OUT (NUM_OUT),
    .W       (W)
  ) u_enq_compact (
    .slot_tags_i (free_register_data),
    .keep_i      (keepMask),
    .free_tags_i (free_phys),
    .free_ok_i   (freeOk),
    .dense_o     (denseTags),
    .count_o     (enqCount)
  );

  // The whole window leaves on a pop; unconsumed slots come back in at the tail ahead of the frees.
  always_comb begin
    fifo_d   = fifo_q;
    inList_d = inList_q;
    for (int j = 0; j < EN; j++) begin
      if (EW'(j) < enqCount) fifo_d[wrapAdd(tail_q, j)] = denseTags[j*PW +: PW];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (pop && frl_ready[k]) inList_d[slotTag[k]] = 1'b0;
    end
    for (int p = 0; p < W; p++) begin
      if (freeOk[p]) inList_d[free_phys[p*PW +: PW]] = 1'b1;
    end
    head_d  = pop ? wrapAdd(head_q, NUM_OUT) : head_q;
    tail_d  = wrapAdd(tail_q, int'(enqCount));
    count_d = count_q - popReady + freeTaken;
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        fifo_q[i]   <= (i < INIT_CNT) ? PW'(NUM_ARCH_REGS + 1 + i) : '0;
        inList_q[i] <= (i > NUM_ARCH_REGS);
      end
      head_q  <= '0;
      tail_q  <= PW'(INIT_CNT);
      count_q <= CW'(INIT_CNT);
    end else begin
      fifo_q   <= fifo_d;
      inList_q <= inList_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // ASSERT_EN lets a caller that drives illegal patterns on purpose silence these reports.
  always @(posedge clk) begin
    if (ASSERT_EN) begin
      if (!frl_valid && (|frl_ready)) $error("free_reg_list: frl_ready while frl_valid is low");
      for (int p = 0; p < W; p++) begin
        if (freeDup[p])  $error("free_reg_list: double free of tag %0d on port %0d", free_phys[p*PW +: PW], p);
        if (freeDrop[p]) $error("free_reg_list: overflow, free of tag %0d dropped", free_phys[p*PW +: PW]);
      end
    end
  end

endmodule

// File: tb/tb_free_reg_list.sv
// Scoreboard bench for free_reg_list: a tag-queue model predicts count, valid and window each cycle.
module tb_free_reg_list;
  import free_reg_list_pkg::*;

  localparam int N  = 64;
  localparam int A  = 32;
  localparam int WW = 2;
  localparam int NO = 6;

  typedef struct packed {
    logic [6:0]  count;
    logic        valid;
    logic [2:0]  n;
    logic [35:0] slots;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [35:0] free_register_data;
  logic        frl_valid;
  logic [5:0]  frl_ready = '0;
  logic [1:0]  free_valid = '0;
  logic [11:0] free_phys = '0;
  logic [6:0]  free_count;

  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];
  int   model[$];
  int   pool[$];
  bit   inList[N];

  always #5 clk = ~clk;

  free_reg_list #(
    .NUM_PHYS_REGS (N),
    .NUM_ARCH_REGS (A),
    .W             (WW),
    .NUM_OUT       (NO),
    .ASSERT_EN     (1'b0)
  ) dut (
    .clk                (clk),
    .rst_in             (rst_in),
    .free_register_data (free_register_data),
    .frl_valid          (frl_valid),
    .frl_ready          (frl_ready),
    .free_valid         (free_valid),
    .free_phys          (free_phys),
    .free_count         (free_count)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    model.delete();
    pool.delete();
    for (int t = 0; t < N; t++) begin
      inList[t] = (t > A);
      if (t > A) model.push_back(t);
      else pool.push_back(t);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e = '0;
    e.count = 7'(model.size());
    e.valid = (model.size() >= NO);
    e.n     = 3'((model.size() < NO) ? model.size() : NO);
    for (int k = 0; k < NO; k++) begin
      if (k < model.size()) e.slots[k*6 +: 6] = 6'(model[k]);
    end
    return e;
  endfunction

  task automatic compareDut();
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("sb_underflow", 0, 1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("count", int'(free_count), int'(e.count));
    checkOutput("valid", int'(frl_valid), int'(e.valid));
    for (int k = 0; k < NO; k++) begin
      if (k < int'(e.n))
        checkOutput($sformatf("slot%0d", k), int'(free_register_data[k*6 +: 6]), int'(e.slots[k*6 +: 6]));
    end
  endtask

  task automatic applyStimulus(input logic [5:0] ready, input logic [1:0] fv, input int f0, input int f1);
    int  win[NO];
    int  tags[2];
    bit  dup[2];
    frl_ready  = ready;
    free_valid = fv;
    free_phys  = {6'(f1), 6'(f0)};
    tags[0] = f0;
    tags[1] = f1;
    dup[0] = fv[0] && inList[f0];
    dup[1] = fv[1] && (inList[f1] || (fv[0] && f0 == f1));
    if (model.size() >= NO && ready != 0) begin
      for (int k = 0; k < NO; k++) win[k] = model.pop_front();
      for (int k = 0; k < NO; k++) begin
        if (ready[k]) begin
          inList[win[k]] = 1'b0;
          pool.push_back(win[k]);
        end else begin
          model.push_back(win[k]);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (fv[p] && !dup[p] && model.size() < N) begin
        model.push_back(tags[p]);
        inList[tags[p]] = 1'b1;
      end
    end
    expQ.push_back(snap());
  endtask

  task automatic step(input logic [5:0] ready, input logic [1:0] fv, input int f0, input int f1);
    applyStimulus(ready, fv, f0, f1);
    @(posedge clk);
    #1;
    frl_ready  = '0;
    free_valid = '0;
    free_phys  = '0;
    compareDut();
  endtask

  task automatic peek();
    expQ.push_back(snap());
    compareDut();
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    #1;
    modelReset();
    peek();
  endtask

  initial begin
    int f0, f1, idx;
    logic [1:0] fv;
    logic [5:0] rdy;

    #1 rst_in = 1'b1;
    #1 rst_in = 1'b0;
    #1;
    modelReset();
    peek();
    checkOutput("rst_count", int'(free_count), 31);
    checkOutput("rst_slot0", int'(free_register_data[5:0]), 33);
    checkOutput("rst_slot5", int'(free_register_data[35:30]), 38);

    step(6'b111111, 2'b00, 0, 0);
    checkOutput("full_count", int'(free_count), 25);
    checkOutput("full_slot0", int'(free_register_data[5:0]), 39);
    checkOutput("full_slot5", int'(free_register_data[35:30]), 44);

    doReset();
    step(6'b110011, 2'b00, 0, 0);
    checkOutput("sparse_count", int'(free_count), 27);
    checkOutput("sparse_slot0", int'(free_register_data[5:0]), 39);
    for (int i = 0; i < 4; i++) step(6'b111111, 2'b00, 0, 0);
    checkOutput("tail_after63", int'(free_register_data[5:0]), 63);
    checkOutput("tail_35", int'(free_register_data[11:6]), 35);
    checkOutput("tail_36", int'(free_register_data[17:12]), 36);
    checkOutput("drain_valid", int'(frl_valid), 0);

    step(6'b111111, 2'b00, 0, 0);
    step(6'b000000, 2'b11, 10, 11);
    step(6'b101010, 2'b00, 0, 0);
    checkOutput("ignored_count", int'(free_count), 5);
    step(6'b000000, 2'b01, 12, 0);
    checkOutput("refill_valid", int'(frl_valid), 1);

    doReset();
    step(6'b111111, 2'b11, 5, 7);
    checkOutput("popfree_count", int'(free_count), 27);
    for (int i = 0; i < 4; i++) step(6'b111111, 2'b00, 0, 0);
    checkOutput("popfree_port0", int'(free_register_data[11:6]), 5);
    checkOutput("popfree_port1", int'(free_register_data[17:12]), 7);

    frl_ready = 6'b111111;
    #2 rst_in = 1'b1;
    #1;
    modelReset();
    peek();
    checkOutput("midrst_count", int'(free_count), 31);
    checkOutput("midrst_slot0", int'(free_register_data[5:0]), 33);
    frl_ready = '0;
    #1 rst_in = 1'b0;
    step(6'b000000, 2'b01, 40, 0);
    checkOutput("dupfree_count", int'(free_count), 31);
    step(6'b000000, 2'b11, 3, 3);
    checkOutput("sameport_count", int'(free_count), 32);

    doReset();
    for (int i = 0; i < 300; i++) begin
      fv = 2'b00;
      f0 = 0;
      f1 = 0;
      if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, pool.size() - 1));
        f0 = pool[idx];
        pool.delete(idx);
        fv[0] = 1'b1;
      end
      if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = int'($urandom_range(0, pool.size() - 1));
        f1 = pool[idx];
        pool.delete(idx);
        fv[1] = 1'b1;
      end
      rdy = ($urandom_range(0, 3) == 0) ? 6'b0 : 6'($urandom_range(1, 63));
      step(rdy, fv, f0, f1);
    end

    checkOutput("sb_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
